if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//   IF stage of the mini rv64 pipeline: holds the fetch PC and runs the instruction-memory request handshake.
//   Delivers one {inst,pc} to ID and takes the next fetch PC from the ID predictor's prdt_pc (combinational on id_inst_o/id_pc_o).
//   EX mispredict redirects override everything, and any in-flight response is discarded.
//   Single outstanding request; no compressed instructions.
// PARAMETERS
//   RESET_PC  64'h0000_0000_8000_0000  first fetch address after reset
// PORTS
//   clk               in   1   clock, all state on rising edge
//   rst               in   1   reset, asynchronous, active-high
//   imem_req_o        out  1   fetch request valid
//   imem_addr_o       out  64  fetch address, bits[1:0] always 0
//   imem_gnt_i        in   1   request accepted this cycle (sampled only while imem_req_o=1)
//   imem_rvalid_i     in   1   response valid; exactly one per granted request, earliest the cycle after gnt
//   imem_rdata_i      in   32  response instruction
//   prdt_pc_i         in   64  predicted next PC for the instruction on id_inst_o/id_pc_o
//   redirect_valid_i  in   1   EX redirect (mispredict), single-cycle pulse
//   redirect_pc_i     in   64  redirect target
//   id_valid_o        out  1   id_inst_o/id_pc_o valid
//   id_inst_o         out  32  instruction to ID
//   id_pc_o           out  64  PC of id_inst_o
//   id_ready_i        in   1   ID accepts the instruction this cycle
//   fetch_cnt_o       out  64  number of instructions accepted by ID since reset
// BEHAVIOUR
//   States: IDLE, REQ, WAIT, DRAIN, VALID. Registers: pc_q, inst_q, ipc_q, cnt_q.
//   Reset (async, while rst=1): state=IDLE, pc_q=RESET_PC, inst_q=0, ipc_q=0, cnt_q=0.
//     Output values under reset: imem_req_o=0, id_valid_o=0, imem_addr_o=RESET_PC.
//   Outputs:
//     imem_req_o = (state==REQ)
//     imem_addr_o = {pc_q[63:2],2'b00}
//     id_valid_o = (state==VALID)
//     id_inst_o = inst_q; id_pc_o = ipc_q; fetch_cnt_o = cnt_q
//   IDLE -> REQ unconditionally on the first edge after rst deasserts.
//   REQ:
//     gnt=1 -> WAIT; ipc_q<=pc_q.
//     gnt=0 -> stay; address held stable.
//   WAIT:
//     rvalid=1 -> VALID; inst_q<=imem_rdata_i.
//   VALID:
//     id_ready_i=1 -> REQ; pc_q<=prdt_pc_i; cnt_q<=cnt_q+1 (wraps mod 2^64).
//     id_ready_i=0 -> hold all outputs.
//   DRAIN:
//     rvalid=1 -> REQ; response dropped (inst_q unchanged).
//   Redirect (redirect_valid_i=1) has priority over all other events:
//     Always pc_q<=redirect_pc_i.
//     IDLE/REQ with gnt=0 -> REQ.
//     REQ with gnt=1 -> DRAIN.
//     WAIT with rvalid=0 -> DRAIN.
//     WAIT with rvalid=1 -> REQ; response dropped.
//     DRAIN with rvalid=0 -> stay DRAIN.
//     DRAIN with rvalid=1 -> REQ.
//     VALID -> REQ; instruction squashed, cnt_q not incremented even if id_ready_i=1.
//   Redirect target bits[1:0] are ignored on the bus (addr masked); pc_q keeps the full value.
//   Latency: best-case delivery interval is 3 cycles (REQ, WAIT, VALID).
//     The request to prdt_pc_i issues the cycle after the ID handshake.
//   No combinational path from any input to imem_req_o or id_valid_o.
// TESTING
//   1. Reset, then deassert rst; gnt=1 every cycle, rvalid the cycle after gnt.
//      -> first request at 0x80000000 in cycle 1; id_pc_o=0x80000000; prdt=pc+4 gives 0x80000004.
//   2. Hold id_ready_i=0 for 5 cycles in VALID.
//      -> id_inst_o/id_pc_o stable, imem_req_o=0, fetch_cnt_o unchanged; after ready=1, fetch_cnt_o=1.
//   3. Redirect to 0x80001000 in WAIT; rvalid arrives 2 cycles later with 0xDEADBEEF.
//      -> DRAIN; 0xDEADBEEF never reaches id_inst_o; next request at 0x80001000.
//   4. Redirect to 0x80002002 on the same cycle as rvalid.
//      -> response dropped; next imem_addr_o=0x80002000, no DRAIN.
//   5. Redirect while VALID with id_ready_i=1.
//      -> fetch_cnt_o unchanged; next request at redirect_pc_i, not prdt_pc_i.
//   6. Assert rst while in WAIT.
//      -> outputs return to reset values immediately (async); after release, restart from 0x80000000.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// ============================================================================
// if_fetch_ctrl : IF stage - fetch PC, single-outstanding imem handshake, ID hand-off
// Rev 1.0
// ============================================================================
`default_nettype none

module if_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic [63:0] prdt_pc_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [63:0] id_pc_o,
  input  logic        id_ready_i,
  output logic [63:0] fetch_cnt_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    VALID = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] ipc_q, ipc_d;
  logic [63:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      ipc_q   <= 64'd0;
      cnt_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    if (redirect_valid_i) begin
      // A granted-but-unanswered request must be drained before refetching.
      pc_d = redirect_pc_i;
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = imem_gnt_i ? DRAIN : REQ;
        WAIT:    state_d = imem_rvalid_i ? REQ : DRAIN;
        DRAIN:   state_d = imem_rvalid_i ? REQ : DRAIN;
        VALID:   state_d = REQ;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt_i) begin
            state_d = WAIT;
            ipc_d   = pc_q;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state_d = VALID;
            inst_d  = imem_rdata_i;
          end
        end
        DRAIN: begin
          if (imem_rvalid_i) state_d = REQ;
        end
        VALID: begin
          if (id_ready_i) begin
            state_d = REQ;
            pc_d    = prdt_pc_i;
            cnt_d   = cnt_q + 64'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = {pc_q[63:2], 2'b00};
  assign id_valid_o  = (state_q == VALID);
  assign id_inst_o   = inst_q;
  assign id_pc_o     = ipc_q;
  assign fetch_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ============================================================================
// tb_if_fetch_ctrl : directed self-checking bench for if_fetch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] prdt_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic        id_ready;
  logic [63:0] fetch_cnt;

  int n_total = 0;
  int n_pass  = 0;

  if_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_gnt_i       (imem_gnt),
    .imem_rvalid_i    (imem_rvalid),
    .imem_rdata_i     (imem_rdata),
    .prdt_pc_i        (prdt_pc),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .id_valid_o       (id_valid),
    .id_inst_o        (id_inst),
    .id_pc_o          (id_pc),
    .id_ready_i       (id_ready),
    .fetch_cnt_o      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequential-fetch predictor stand-in.
  assign prdt_pc = id_pc + 64'd4;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 64'd0; id_ready = 1'b0;
    #12;
    check("rst_req",   {63'd0, imem_req}, 64'd0);
    check("rst_valid", {63'd0, id_valid}, 64'd0);
    check("rst_addr",  imem_addr, 64'h8000_0000);
    check("rst_cnt",   fetch_cnt, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: first fetch
    step();
    check("t1_req",   {63'd0, imem_req}, 64'd1);
    check("t1_addr",  imem_addr, 64'h8000_0000);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    check("t1_wait_req", {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; step(); imem_rvalid = 1'b0;
    check("t1_valid", {63'd0, id_valid}, 64'd1);
    check("t1_pc",    id_pc, 64'h8000_0000);
    check("t1_inst",  {32'd0, id_inst}, 64'h13);

    // 2: ID stall
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_valid", {63'd0, id_valid}, 64'd1);
      check("t2_inst",  {32'd0, id_inst}, 64'h13);
      check("t2_pc",    id_pc, 64'h8000_0000);
      check("t2_req",   {63'd0, imem_req}, 64'd0);
      check("t2_cnt",   fetch_cnt, 64'd0);
    end
    id_ready = 1'b1; step(); id_ready = 1'b0;
    check("t2_cnt1",  fetch_cnt, 64'd1);
    check("t2_req1",  {63'd0, imem_req}, 64'd1);
    check("t2_addr",  imem_addr, 64'h8000_0004);

    // 3: redirect in WAIT, late response drained
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000; step(); redirect_valid = 1'b0;
    check("t3_drain_req",   {63'd0, imem_req}, 64'd0);
    check("t3_drain_valid", {63'd0, id_valid}, 64'd0);
    step();
    check("t3_drain2_req",  {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 1'b0;
    check("t3_req",   {63'd0, imem_req}, 64'd1);
    check("t3_addr",  imem_addr, 64'h8000_1000);
    check("t3_valid", {63'd0, id_valid}, 64'd0);
    check("t3_inst",  {32'd0, id_inst}, 64'h13);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093; step(); imem_rvalid = 1'b0;
    check("t3_pc2",   id_pc, 64'h8000_1000);
    check("t3_inst2", {32'd0, id_inst}, 64'h0010_0093);
    id_ready = 1'b1; step(); id_ready = 1'b0;
    check("t3_addr2", imem_addr, 64'h8000_1004);
    check("t3_cnt",   fetch_cnt, 64'd2);

    // 4: redirect coincident with rvalid
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_BABE;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2002;
    step();
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
    check("t4_req",   {63'd0, imem_req}, 64'd1);
    check("t4_addr",  imem_addr, 64'h8000_2000);
    check("t4_valid", {63'd0, id_valid}, 64'd0);
    check("t4_inst",  {32'd0, id_inst}, 64'h0010_0093);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_0113; step(); imem_rvalid = 1'b0;
    check("t4_pc",    id_pc, 64'h8000_2002);
    check("t4_inst2", {32'd0, id_inst}, 64'h0020_0113);

    // 5: redirect squashes an accepted instruction
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    step();
    id_ready = 1'b0; redirect_valid = 1'b0;
    check("t5_cnt",   fetch_cnt, 64'd2);
    check("t5_req",   {63'd0, imem_req}, 64'd1);
    check("t5_addr",  imem_addr, 64'h8000_3000);
    check("t5_valid", {63'd0, id_valid}, 64'd0);

    // 6: async reset while WAIT
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    check("t6_wait_req",  {63'd0, imem_req}, 64'd0);
    check("t6_wait_addr", imem_addr, 64'h8000_3000);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_req",   {63'd0, imem_req}, 64'd0);
    check("t6_rst_valid", {63'd0, id_valid}, 64'd0);
    check("t6_rst_addr",  imem_addr, 64'h8000_0000);
    check("t6_rst_cnt",   fetch_cnt, 64'd0);
    check("t6_rst_pc",    id_pc, 64'd0);
    check("t6_rst_inst",  {32'd0, id_inst}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    step();
    check("t6_req",  {63'd0, imem_req}, 64'd1);
    check("t6_addr", imem_addr, 64'h8000_0000);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0030_0193; step(); imem_rvalid = 1'b0;
    check("t6_pc",   id_pc, 64'h8000_0000);
    id_ready = 1'b1; step(); id_ready = 1'b0;
    check("t6_cnt",  fetch_cnt, 64'd1);
    check("t6_addr2", imem_addr, 64'h8000_0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
